// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: serial timing and the
// scheduler state encoding used by uart_tx_buffer.
package uart_pkg;

  localparam int BAUD           = 115200;
  localparam int SYS_CLK_PERIOD = 50;
  localparam int BAUD_CYCLES    = (1_000_000_000 + (BAUD * SYS_CLK_PERIOD) / 2)
                                  / (BAUD * SYS_CLK_PERIOD);
  localparam int BAUD_CNT_END   = BAUD_CYCLES - 1;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t IDLE      = 2'd0;
  localparam tx_state_t REQ       = 2'd1;
  localparam tx_state_t WAIT_BUSY = 2'd2;
  localparam tx_state_t WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered full/empty/level flags and an
// overflow pulse for writes dropped while full.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  SYS_CLK,
  input  logic                  RST_N,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [DEPTH_LOG2:0] wr_ptr_n;
  logic [DEPTH_LOG2:0] rd_ptr_n;
  logic [DEPTH_LOG2:0] level_n;
  logic                do_write;
  logic                do_read;

  // Full is judged on the registered flag, so a pop on the same edge
  // does not rescue a write into a full FIFO.
  assign do_write = wr_en && !full && !flush;
  assign do_read  = rd_en && !empty && !flush;
  assign rd_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end else begin
      if (do_write) wr_ptr_n = wr_ptr + PTR_ONE;
      if (do_read)  rd_ptr_n = rd_ptr + PTR_ONE;
    end
    level_n = wr_ptr_n - rd_ptr_n;
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      level    <= level_n;
      full     <= (level_n == FULL_LEVEL);
      empty    <= (level_n == '0);
      overflow <= wr_en && full && !flush;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (do_write) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer and send scheduler feeding the UART transmitter: pops one
// byte per frame, pulses tx_req, and re-requests if tx_busy never rises.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                SYS_CLK,
  input  logic                RST_N,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                flush,
  input  logic                tx_busy,
  output logic                tx_req,
  output logic [7:0]          tx_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow
);

  localparam int               CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_t        state;
  logic [CNT_W-1:0] busy_cnt;
  logic [7:0]       fifo_data;
  logic             pop;

  assign pop = (state == IDLE) && !empty && !flush;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .SYS_CLK  (SYS_CLK),
    .RST_N    (RST_N),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .flush    (flush),
    .rd_data  (fifo_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // tx_data is only loaded on the pop edge; retries resend the held byte
  // and a flush leaves it alone.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      tx_req   <= 1'b0;
      tx_data  <= 8'h00;
      busy_cnt <= '0;
    end else if (flush) begin
      state    <= IDLE;
      tx_req   <= 1'b0;
      busy_cnt <= '0;
    end else begin
      tx_req <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= fifo_data;
            tx_req  <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == CNT_LAST) begin
            tx_req <= 1'b1;
            state  <= REQ;
          end else begin
            busy_cnt <= busy_cnt + CNT_ONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: directed writes push expected bytes,
// a monitor checks every tx_req against the queue; a stub models tx_busy.
module tb_uart_tx_buffer;

  localparam int DEPTH_LOG2   = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int FRAME_CYCLES = 40;

  logic                SYS_CLK;
  logic                RST_N;
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                flush;
  logic                tx_busy;
  logic                tx_req;
  logic [7:0]          tx_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;

  int         checks    = 0;
  int         errors    = 0;
  int         req_count = 0;
  int         busy_cnt  = 0;
  bit         stub_en   = 1'b1;
  logic [7:0] exp_q[$];

  uart_tx_buffer #(
    .DEPTH_LOG2   (DEPTH_LOG2),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .SYS_CLK  (SYS_CLK),
    .RST_N    (RST_N),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .tx_busy  (tx_busy),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  initial begin
    SYS_CLK = 1'b0;
    forever #25 SYS_CLK = ~SYS_CLK;
  end

  initial begin
    #(50 * 30000);
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stub transmitter: latches a request when idle and stays busy for a frame.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge SYS_CLK);
      #5;
      if (!RST_N || !stub_en) begin
        tx_busy  = 1'b0;
        busy_cnt = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end else if (tx_req) begin
        tx_busy  = 1'b1;
        busy_cnt = FRAME_CYCLES;
      end
    end
  end

  // Monitor: every request must carry the next expected byte, never follow
  // a request or a busy cycle directly, and tx_data may only move on a request.
  initial begin
    logic       prev_req;
    logic       prev_busy;
    logic [7:0] prev_data;
    prev_req  = 1'b0;
    prev_busy = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge SYS_CLK);
      if (!RST_N) begin
        prev_req  = 1'b0;
        prev_busy = 1'b0;
        prev_data = 8'h00;
      end else begin
        if (tx_req) begin
          req_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_req: actual=%02h required=none", tx_data);
          end else if (tx_data !== exp_q[0]) begin
            errors++;
            $display("[TB] FAIL req_data: actual=%02h required=%02h", tx_data, exp_q[0]);
          end
          if (stub_en && exp_q.size() > 0) void'(exp_q.pop_front());
          checks++;
          if (prev_req || prev_busy) begin
            errors++;
            $display("[TB] FAIL req_spacing: actual=req_after(req=%0b,busy=%0b) required=idle",
                     prev_req, prev_busy);
          end
        end else if (tx_data !== prev_data) begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_data_hold: actual=%02h required=%02h", tx_data, prev_data);
        end
        prev_req  = tx_req;
        prev_busy = tx_busy;
        prev_data = tx_data;
      end
    end
  end

  // Drive one cycle of inputs just after a rising edge.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic f);
    @(posedge SYS_CLK);
    #1;
    wr_en   = w;
    wr_data = d;
    flush   = f;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Wait until the scoreboard is drained and the DUT has been quiet a while.
  task automatic waitQuiet(input int limit, input string name);
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 5 && n < limit) begin
      @(negedge SYS_CLK);
      n++;
      if (exp_q.size() == 0 && !tx_busy && empty && !tx_req) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 5) begin
      errors++;
      $display("[TB] FAIL %s: actual=pending(%0d) required=drained", name, exp_q.size());
    end
  endtask

  task automatic waitReq(input int limit, input string name, output int n);
    n = 0;
    do begin
      @(negedge SYS_CLK);
      n++;
    end while (!tx_req && n < limit);
    if (!tx_req) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: actual=no_req required=req", name);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tx_req"},   32'(tx_req),   32'd0);
    checkOutput({tag, "_tx_data"},  32'(tx_data),  32'h00);
    checkOutput({tag, "_full"},     32'(full),     32'd0);
    checkOutput({tag, "_empty"},    32'(empty),    32'd1);
    checkOutput({tag, "_level"},    32'(level),    32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int         n;
    int         reqs;
    logic [7:0] flush_bytes[5];
    logic [7:0] reset_bytes[6];
    flush_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    reset_bytes = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};

    RST_N   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    checkResetValues("rst");
    RST_N = 1'b1;

    // Single byte: request lands two edges after the write.
    exp_q.push_back(8'hA5);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge SYS_CLK);
    checkOutput("t1_empty_after_wr", 32'(empty), 32'd0);
    checkOutput("t1_level_after_wr", 32'(level), 32'd1);
    checkOutput("t1_req_not_yet",    32'(tx_req), 32'd0);
    @(negedge SYS_CLK);
    checkOutput("t1_req_pulse",      32'(tx_req), 32'd1);
    checkOutput("t1_tx_data",        32'(tx_data), 32'hA5);
    checkOutput("t1_level_popped",   32'(level), 32'd0);
    @(negedge SYS_CLK);
    checkOutput("t1_req_one_cycle",  32'(tx_req), 32'd0);
    waitQuiet(200, "t1_drain");
    checkOutput("t1_empty_final",    32'(empty), 32'd1);

    // Burst while the transmitter is busy with 8'hEE: fill, then overflow.
    exp_q.push_back(8'hEE);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      applyStimulus(1'b1, 8'(i), 1'b0);
    end
    applyStimulus(1'b1, 8'hFF, 1'b0);
    @(negedge SYS_CLK);
    checkOutput("t2_full",          32'(full), 32'd1);
    checkOutput("t2_level_16",      32'(level), 32'd16);
    checkOutput("t2_no_overflow",   32'(overflow), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge SYS_CLK);
    checkOutput("t2_overflow",      32'(overflow), 32'd1);
    checkOutput("t2_level_kept",    32'(level), 32'd16);
    checkOutput("t2_full_kept",     32'(full), 32'd1);
    @(negedge SYS_CLK);
    checkOutput("t2_overflow_1cyc", 32'(overflow), 32'd0);
    waitQuiet(2000, "t2_drain");
    checkOutput("t2_level_drained", 32'(level), 32'd0);

    // Write on the same edge as the pop: level unchanged, 3C follows 77.
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h3C);
    applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge SYS_CLK);
    checkOutput("t3_level_same", 32'(level), 32'd1);
    checkOutput("t3_req",        32'(tx_req), 32'd1);
    checkOutput("t3_tx_data",    32'(tx_data), 32'h77);
    waitQuiet(300, "t3_drain");

    // Timeout: with tx_busy held low the same byte is re-requested.
    @(posedge SYS_CLK);
    #1;
    stub_en = 1'b0;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h4D);
    applyStimulus(1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b1, 8'h4D, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge SYS_CLK);
    checkOutput("t4_first_req",  32'(tx_req), 32'd1);
    checkOutput("t4_first_data", 32'(tx_data), 32'hC3);
    for (int k = 0; k < 2; k++) begin
      waitReq(40, "t4_retry_req", n);
      checkOutput("t4_retry_period", 32'(n), 32'(BUSY_TIMEOUT + 1));
      checkOutput("t4_retry_data",   32'(tx_data), 32'hC3);
      checkOutput("t4_level_kept",   32'(level), 32'd1);
    end
    @(posedge SYS_CLK);
    #1;
    stub_en = 1'b1;
    waitQuiet(300, "t4_drain");

    // Flush during WAIT_DONE of the first of five bytes.
    foreach (flush_bytes[i]) begin
      exp_q.push_back(flush_bytes[i]);
      applyStimulus(1'b1, flush_bytes[i], 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge SYS_CLK);
    checkOutput("t5_level_before", 32'(level), 32'd4);
    applyStimulus(1'b0, 8'h00, 1'b0);
    exp_q.delete();
    @(negedge SYS_CLK);
    checkOutput("t5_level_flushed", 32'(level), 32'd0);
    checkOutput("t5_empty_flushed", 32'(empty), 32'd1);
    checkOutput("t5_req_low",       32'(tx_req), 32'd0);
    checkOutput("t5_tx_data_kept",  32'(tx_data), 32'h11);
    reqs = req_count;
    n = 0;
    while (tx_busy && n < 100) begin
      @(negedge SYS_CLK);
      n++;
    end
    checkOutput("t5_frame_finished", 32'(tx_busy), 32'd0);
    repeat (40) @(negedge SYS_CLK);
    checkOutput("t5_no_req_after",  32'(req_count - reqs), 32'd0);
    checkOutput("t5_empty_final",   32'(empty), 32'd1);

    // Asynchronous reset in the middle of a burst, then a clean byte.
    foreach (reset_bytes[i]) begin
      exp_q.push_back(reset_bytes[i]);
      applyStimulus(1'b1, reset_bytes[i], 1'b0);
    end
    @(posedge SYS_CLK);
    #9;
    wr_en = 1'b0;
    checkOutput("t6_level_mid_burst", 32'(level), 32'd5);
    #1;
    RST_N = 1'b0;
    #1;
    checkResetValues("t6_async");
    exp_q.delete();
    repeat (2) @(negedge SYS_CLK);
    RST_N = 1'b1;
    reqs = req_count;
    exp_q.push_back(8'h5A);
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitQuiet(300, "t6_drain");
    checkOutput("t6_single_req", 32'(req_count - reqs), 32'd1);
    checkOutput("t6_empty",      32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Byte FIFO and transmit scheduler that sits directly upstream of the UART transmitter. It accepts bytes from the SDRAM read-back path in single-cycle writes. It drains them one at a time into the transmitter using a tx_req pulse, tracking the transmitter's tx_busy to know when each frame is done. It absorbs SDRAM burst rates against the slow serial rate.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries)
BUSY_TIMEOUT, 16, SYS_CLK cycles to wait for tx_busy to rise after tx_req before re-issuing the request

Ports:
SYS_CLK  input  1  system clock (50 ns period, 20 MHz)
RST_N  input  1  reset, asynchronous, active-low
wr_en  input  1  write strobe; one byte per cycle
wr_data  input  8  byte to enqueue
flush  input  1  synchronous clear of FIFO contents and scheduler
tx_busy  input  1  from transmitter; high while a frame is latched or being sent
tx_req  output  1  single-cycle send request to transmitter
tx_data  output  8  byte presented to transmitter
full  output  1  FIFO holds 2^DEPTH_LOG2 entries
empty  output  1  FIFO holds 0 entries
level  output  DEPTH_LOG2+1  current entry count
overflow  output  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset values (async, RST_N low): tx_req=0, tx_data=8'h00, full=0, empty=1, level=0, overflow=0; pointers=0; FSM=IDLE. Reset mid-frame abandons the byte in flight.
- FIFO: dual pointers of width DEPTH_LOG2+1; the MSB distinguishes full from empty. full, empty and level are registered and reflect the state after the previous edge.
- Write: if wr_en=1 and full=0, store at wr_ptr and increment (wraps naturally).
- Write while full: byte is dropped, overflow pulses for 1 cycle. This applies even if a pop occurs on the same edge.
- Simultaneous write and pop: both take effect; level is unchanged.
- FSM states: IDLE, REQ, WAIT_BUSY, WAIT_DONE.
- IDLE: if empty=0 → REQ. On this edge tx_data<=mem[rd_ptr], rd_ptr+1 (pop), and tx_req<=1.
- REQ (1 cycle): tx_req<=0; → WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY: tx_data held.
  - tx_busy=1 → WAIT_DONE.
  - counter reaches BUSY_TIMEOUT-1 → REQ, pulsing tx_req again with the same tx_data. No re-pop.
- WAIT_DONE: tx_data held. tx_busy=0 → IDLE.
- Next-byte spacing: the next tx_req can assert no earlier than 1 cycle after tx_busy falls. There is no back-to-back request while the transmitter is busy.
- Latency: wr_en into an empty, idle block at edge N gives empty=0 after N; tx_req is high for the cycle following edge N+1.
- tx_req is never high for 2 consecutive cycles.
- tx_data changes only on the IDLE→REQ edge.
- flush=1 (sync): pointers, level and timeout counter cleared; empty=1; FSM→IDLE; tx_req=0; tx_data retains its value.
  - flush has priority over wr_en and pop in the same cycle.
  - Flushing during WAIT_DONE does not stop the frame already on the line.
- tx_busy glitch/high while in IDLE: ignored.

Decomposition:
- Shared package uart_pkg: BAUD=115200, SYS_CLK_PERIOD=50, BAUD_CNT_END, FSM state encoding (2-bit localparams IDLE/REQ/WAIT_BUSY/WAIT_DONE).
- One natural sub-module: sync_fifo (parameterised DEPTH_LOG2, WIDTH=8; provides wr/rd/flush, full/empty/level). The scheduler FSM stays in uart_tx_buffer.

Test Plan:
1. Single byte: reset, write 8'hA5 → tx_req is one 1-cycle pulse 2 cycles later with tx_data=8'hA5. With the real transmitter attached, Txd shows 0,1,0,1,0,0,1,0,1,1 at 174 cycles/bit; empty=1 afterward.
2. Burst: write 8'h00..8'h0F on 16 consecutive cycles → full=1, level=16. A 17th write of 8'hFF is dropped, with an overflow pulse. Serial output is exactly 00..0F in order; no tx_req while tx_busy=1.
3. Write during pop: with level=1 and the FSM entering REQ, write 8'h3C on the same edge → level stays 1; 8'h3C is sent next.
4. Timeout: hold tx_busy=0 with a stub transmitter → tx_req re-pulses every BUSY_TIMEOUT+1 cycles with the unchanged tx_data; level is not decremented.
5. Flush: load 5 bytes and assert flush during WAIT_DONE of the first → the current frame completes, then no further tx_req; level=0, empty=1.
6. Async reset: assert RST_N=0 mid-burst between clock edges → all outputs are at reset values immediately. After release, writing 8'h5A produces a clean single transmission.
